// File: rtl/jump_trajectory_pkg.sv
// Shared types and constants for the jump trajectory engine.
// Holds FSM encoding, Q4 fixed-point constants and pixel conversion helpers.
package jump_trajectory_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLY,
        S_DONE
    } jump_state_e;

    localparam int          FRAC_BITS  = 4;
    localparam int          V_MAX      = 127;
    localparam logic [14:0] X_MAX      = 15'h7FFF;
    localparam logic [8:0]  HEIGHT_MAX = 9'd511;

    // Clamp the charge-derived launch speed to the meaningful range.
    function automatic logic [6:0] clamp_v(input logic [10:0] v);
        return (v > 11'(V_MAX)) ? 7'(V_MAX) : v[6:0];
    endfunction

    // Q4 height to integer pixels, saturating at the 9-bit output range.
    function automatic logic [8:0] height_px(input logic signed [13:0] h);
        logic [13:0] u;
        logic [9:0]  px;
        u  = h[13] ? 14'd0 : unsigned'(h);
        px = 10'(u >> FRAC_BITS);
        return (px > {1'b0, HEIGHT_MAX}) ? HEIGHT_MAX : px[8:0];
    endfunction

    // Q4 distance to integer pixels; x is already saturated at X_MAX.
    function automatic logic [10:0] dist_px(input logic [14:0] x);
        return 11'(x >> FRAC_BITS);
    endfunction

endpackage

// File: rtl/jump_trajectory_if.sv
// Handshake bundle between the game FSM (master) and the jump engine (slave).
// Signals: i_jump_en, i_jump_v_init in; o_jump_done/dist/height (+o_jump_apex with JUMP_APEX_EN) out.
interface jump_trajectory_if;

    logic        i_jump_en;
    logic [10:0] i_jump_v_init;
    logic        o_jump_done;
    logic [10:0] o_jump_dist;
    logic [8:0]  o_jump_height;
`ifdef JUMP_APEX_EN
    logic        o_jump_apex;
`endif

    modport master (
        output i_jump_en,
        output i_jump_v_init,
        input  o_jump_done,
        input  o_jump_dist,
`ifdef JUMP_APEX_EN
        input  o_jump_apex,
`endif
        input  o_jump_height
    );

    modport slave (
        input  i_jump_en,
        input  i_jump_v_init,
        output o_jump_done,
        output o_jump_dist,
`ifdef JUMP_APEX_EN
        output o_jump_apex,
`endif
        output o_jump_height
    );

endinterface

// File: rtl/jump_trajectory_tick_gen.sv
// Physics step timer: counts TICK_DIV cycles and strobes o_tick on the last one.
// Ports: i_clk, i_rst (async high), i_clr (sync clear), i_en (count), o_tick.
module jump_tick_gen #(
    parameter int TICK_DIV = 196608
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en && w_last && !i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jump_trajectory.sv
// Ballistic jump engine: latches launch speed, steps height/distance per tick, flags landing.
// Ports: clk_jump, rst_jump (async high), io_bus (slave); JUMP_APEX_EN adds o_jump_apex.
module jump_trajectory
    import jump_trajectory_pkg::*;
#(
    parameter int TICK_DIV = 196608,
    parameter int GRAV_Q4  = 2,
    parameter int VX_Q4    = 32
) (
    input  logic              clk_jump,
    input  logic              rst_jump,
    jump_trajectory_if.slave  io_bus
);

    localparam logic signed [8:0] GRAV = 9'(GRAV_Q4);

    jump_state_e        r_state, w_state_n;
    logic signed [8:0]  r_vy, w_vy_n, w_vy_step;
    logic signed [13:0] r_h_q, w_h_n;
    logic signed [14:0] w_h_next;
    logic [14:0]        r_x_q, w_x_n, w_x_step;
    logic [15:0]        w_x_sum;
    logic [10:0]        r_dist, w_dist_n;
    logic [8:0]         r_height, w_height_n;
    logic               r_done, w_done_n;
    logic               w_start, w_tick;
`ifdef JUMP_APEX_EN
    logic               r_apex, w_apex_n;
`endif

    assign w_start = (r_state == S_IDLE) && io_bus.i_jump_en;

    jump_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk  (clk_jump),
        .i_rst  (rst_jump),
        .i_clr  (w_start),
        .i_en   (r_state == S_FLY),
        .o_tick (w_tick)
    );

    assign w_vy_step = r_vy - GRAV;
    assign w_h_next  = 15'(r_h_q) + 15'(r_vy);
    assign w_x_sum   = {1'b0, r_x_q} + 16'(VX_Q4);
    assign w_x_step  = w_x_sum[15] ? X_MAX : w_x_sum[14:0];

    always_ff @(posedge clk_jump or posedge rst_jump) begin
        if (rst_jump) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_vy_n     = r_vy;
        w_h_n      = r_h_q;
        w_x_n      = r_x_q;
        w_dist_n   = r_dist;
        w_height_n = r_height;
        w_done_n   = r_done;
`ifdef JUMP_APEX_EN
        w_apex_n   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.i_jump_en) begin
                    w_vy_n     = signed'({2'b00, clamp_v(io_bus.i_jump_v_init)});
                    w_h_n      = '0;
                    w_x_n      = '0;
                    w_dist_n   = '0;
                    w_height_n = '0;
                    w_done_n   = 1'b0;
                    w_state_n  = S_FLY;
                end
            end
            S_FLY: begin
                if (!io_bus.i_jump_en) begin
                    w_dist_n   = '0;
                    w_height_n = '0;
                    w_done_n   = 1'b0;
                    w_state_n  = S_IDLE;
                end else begin
                    // Outputs trail the datapath by one cycle.
                    w_dist_n   = dist_px(r_x_q);
                    w_height_n = height_px(r_h_q);
                    if (w_tick) begin
                        w_vy_n = w_vy_step;
                        w_x_n  = w_x_step;
`ifdef JUMP_APEX_EN
                        w_apex_n = (r_vy > 9'sd0) && (w_vy_step <= 9'sd0);
`endif
                        if (w_h_next <= 15'sd0) begin
                            w_h_n      = '0;
                            w_height_n = '0;
                            w_done_n   = 1'b1;
                            w_state_n  = S_DONE;
                        end else begin
                            w_h_n = w_h_next[13:0];
                        end
                    end
                end
            end
            S_DONE: begin
                w_dist_n   = dist_px(r_x_q);
                w_height_n = '0;
                if (!io_bus.i_jump_en) begin
                    w_done_n  = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_jump or posedge rst_jump) begin
        if (rst_jump) begin
            r_vy     <= '0;
            r_h_q    <= '0;
            r_x_q    <= '0;
            r_dist   <= '0;
            r_height <= '0;
            r_done   <= 1'b0;
        end else begin
            r_vy     <= w_vy_n;
            r_h_q    <= w_h_n;
            r_x_q    <= w_x_n;
            r_dist   <= w_dist_n;
            r_height <= w_height_n;
            r_done   <= w_done_n;
        end
    end

`ifdef JUMP_APEX_EN
    always_ff @(posedge clk_jump or posedge rst_jump) begin
        if (rst_jump) begin
            r_apex <= 1'b0;
        end else begin
            r_apex <= w_apex_n;
        end
    end

    assign io_bus.o_jump_apex = r_apex;
`endif

    assign io_bus.o_jump_done   = r_done;
    assign io_bus.o_jump_dist   = r_dist;
    assign io_bus.o_jump_height = r_height;

endmodule

// File: tb/tb_jump_trajectory.sv
// Directed bench for jump_trajectory with TICK_DIV=4 (step n lands on edge 4n after launch).
// Optional JUMP_APEX_EN build adds apex pulse checks.
module tb_jump_trajectory;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    jump_trajectory_if bus ();

    jump_trajectory #(
        .TICK_DIV (4),
        .GRAV_Q4  (2),
        .VX_Q4    (32)
    ) dut (
        .clk_jump (clk),
        .rst_jump (rst),
        .io_bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch at a negedge and watch outputs each negedge until done or timeout.
    // Observation cycle c sees the registers after edge c-1 (edge 0 = launch).
    task automatic fly(input logic [10:0] v, output int done_cyc,
                       output int maxh, output int peak_cyc,
                       output int apex_n, output int apex_cyc);
        int cyc;
        done_cyc = -1;
        maxh     = -1;
        peak_cyc = -1;
        apex_n   = 0;
        apex_cyc = -1;
        bus.i_jump_v_init = v;
        bus.i_jump_en     = 1'b1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (int'(bus.o_jump_height) > maxh) begin
                maxh     = int'(bus.o_jump_height);
                peak_cyc = cyc;
            end
`ifdef JUMP_APEX_EN
            if (bus.o_jump_apex === 1'b1) begin
                apex_n++;
                apex_cyc = cyc;
            end
`endif
            if (bus.o_jump_done === 1'b1) done_cyc = cyc;
        end
    endtask

    initial begin
        int dc, mh, pc, an, ac;
        int done_seen;

        bus.i_jump_en     = 1'b0;
        bus.i_jump_v_init = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done", bus.o_jump_done, 0);
        chk("rst_dist", bus.o_jump_dist, 0);
        chk("rst_height", bus.o_jump_height, 0);
`ifdef JUMP_APEX_EN
        chk("rst_apex", bus.o_jump_apex, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // v=127: 128 steps, peak 256 px at step 64, lands at dist 256
        fly(11'd127, dc, mh, pc, an, ac);
        chk("v127_done_cyc", dc, 513);
        chk("v127_peak", mh, 256);
        chk("v127_peak_cyc", pc, 258);
`ifdef JUMP_APEX_EN
        chk("v127_apex_cnt", an, 1);
        chk("v127_apex_cyc", ac, 257);
`endif
        chk("v127_land_height", bus.o_jump_height, 0);
        chk("v127_pre_dist", bus.o_jump_dist, 254);
        @(negedge clk);
        chk("v127_dist", bus.o_jump_dist, 256);
        chk("v127_done_hold", bus.o_jump_done, 1);
        bus.i_jump_en = 1'b0;
        @(negedge clk);
        chk("v127_done_drop", bus.o_jump_done, 0);
        chk("v127_dist_idle", bus.o_jump_dist, 256);
        chk("v127_height_idle", bus.o_jump_height, 0);

        // v=63: peak 64 px at step 32, lands at step 64, dist 128
        fly(11'd63, dc, mh, pc, an, ac);
        chk("v63_done_cyc", dc, 257);
        chk("v63_peak", mh, 64);
        chk("v63_peak_cyc", pc, 130);
`ifdef JUMP_APEX_EN
        chk("v63_apex_cnt", an, 1);
        chk("v63_apex_cyc", ac, 129);
`endif
        @(negedge clk);
        chk("v63_dist", bus.o_jump_dist, 128);
        bus.i_jump_en = 1'b0;
        @(negedge clk);
        chk("v63_done_drop", bus.o_jump_done, 0);
        chk("v63_dist_idle", bus.o_jump_dist, 128);
        @(negedge clk);
        chk("v63_dist_idle2", bus.o_jump_dist, 128);

        // v=0: lands on the first step with dist 2
        fly(11'd0, dc, mh, pc, an, ac);
        chk("v0_done_cyc", dc, 5);
        chk("v0_peak", mh, 0);
`ifdef JUMP_APEX_EN
        chk("v0_apex_cnt", an, 0);
`endif
        @(negedge clk);
        chk("v0_dist", bus.o_jump_dist, 2);
        chk("v0_height", bus.o_jump_height, 0);
        bus.i_jump_en = 1'b0;
        @(negedge clk);

        // v=2047 clamps to 127
        fly(11'd2047, dc, mh, pc, an, ac);
        chk("vclamp_done_cyc", dc, 513);
        chk("vclamp_peak", mh, 256);
        chk("vclamp_peak_cyc", pc, 258);
        @(negedge clk);
        chk("vclamp_dist", bus.o_jump_dist, 256);
        bus.i_jump_en = 1'b0;
        @(negedge clk);

        // Abort v=100 right after step 20
        done_seen = 0;
        bus.i_jump_v_init = 11'd100;
        bus.i_jump_en     = 1'b1;
        repeat (81) begin
            @(negedge clk);
            if (bus.o_jump_done === 1'b1) done_seen = 1;
        end
        chk("abort_height_s19", bus.o_jump_height, 97);
        chk("abort_dist_s19", bus.o_jump_dist, 38);
        bus.i_jump_en = 1'b0;
        @(negedge clk);
        chk("abort_done", bus.o_jump_done, 0);
        chk("abort_dist", bus.o_jump_dist, 0);
        chk("abort_height", bus.o_jump_height, 0);
        repeat (3) begin
            @(negedge clk);
            if (bus.o_jump_done === 1'b1) done_seen = 1;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle_dist", bus.o_jump_dist, 0);

        // Async reset around step 50 of a v=127 jump
        bus.i_jump_v_init = 11'd127;
        bus.i_jump_en     = 1'b1;
        repeat (201) @(negedge clk);
        chk("rstmid_height_s49", bus.o_jump_height, 241);
        chk("rstmid_dist_s49", bus.o_jump_dist, 98);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_done", bus.o_jump_done, 0);
        chk("rstmid_dist", bus.o_jump_dist, 0);
        chk("rstmid_height", bus.o_jump_height, 0);
        bus.i_jump_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fly(11'd63, dc, mh, pc, an, ac);
        chk("postrst_done_cyc", dc, 257);
        chk("postrst_peak", mh, 64);
        @(negedge clk);
        chk("postrst_dist", bus.o_jump_dist, 128);
        bus.i_jump_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
